// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch-stage sequencer. Owns the PC, keeps at most one request in flight to
//   a variable-latency instruction memory, and hands fetched instructions to
//   decode over a valid/ready handshake. Redirects from execute have priority
//   over every other event and squash any response still in flight.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   imem_req / imem_addr      request strobe and address (address = current PC)
//   imem_rvalid / imem_rdata  memory response
//   if_valid / if_ready       handshake to decode
//   if_instr / if_pc          instruction presented to decode and its PC
//   redirect / redirect_target  taken branch/jump and its destination
//   fetch_fault               sticky misaligned-target trap
//
// Build option
//   FETCH_MISALIGN_CHK_EN: when defined, a redirect to a target whose two low
//   bits are non-zero raises fetch_fault and parks the sequencer in HALT until
//   reset (after first absorbing any response still in flight). When
//   undefined, fetch_fault is tied low and targets are used as given.
module fetch_ctrl #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [DATA_WIDTH-1:0]    if_instr,
  output logic [ADDRESS_WIDTH-1:0] if_pc,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     fetch_fault
);

  typedef enum logic [2:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DROP,
    ST_HALT
  } state_t;

  state_t                   state_reg;
  logic [ADDRESS_WIDTH-1:0] pc_reg;
  logic                     if_valid_reg;
  logic [DATA_WIDTH-1:0]    if_instr_reg;
  logic [ADDRESS_WIDTH-1:0] if_pc_reg;

  // A request is in flight in WAIT and DROP. A redirect that lands while the
  // response has not yet arrived must go through DROP to swallow it.
  logic resp_pending;
  logic squash_to_drop;
  logic redirect_ok;

  assign resp_pending   = (state_reg == ST_WAIT) || (state_reg == ST_DROP);
  assign squash_to_drop = resp_pending && !imem_rvalid;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_reg;
  logic halt_pending_reg;
  logic misaligned;

  assign misaligned  = redirect_target[1:0] != 2'b00;
  // Once a fault has been taken, further redirects are ignored, including
  // while the in-flight response is still being absorbed.
  assign redirect_ok = redirect && (state_reg != ST_HALT) && !halt_pending_reg;
  assign fetch_fault = fault_reg;
`else
  assign redirect_ok = redirect;
  assign fetch_fault = 1'b0;
`endif

  // Requests are issued from ISSUE, or straight out of HOLD in the same cycle
  // decode takes the held instruction. Any redirect suppresses the request.
  assign imem_req  = !rst && !redirect &&
                     ((state_reg == ST_ISSUE) ||
                      ((state_reg == ST_HOLD) && if_ready));
  assign imem_addr = pc_reg;

  assign if_valid = if_valid_reg;
  assign if_instr = if_instr_reg;
  assign if_pc    = if_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_ISSUE;
      pc_reg           <= RESET_PC;
      if_valid_reg     <= 1'b0;
      if_instr_reg     <= '0;
      if_pc_reg        <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_reg        <= 1'b0;
      halt_pending_reg <= 1'b0;
`endif
    end else if (redirect_ok) begin
      pc_reg       <= redirect_target;
      if_valid_reg <= 1'b0;
      // If the response arrives in the redirect cycle itself it is simply
      // dropped here, so no DROP detour is needed (this also applies in DROP,
      // which would otherwise wait for a response that has already gone by).
`ifdef FETCH_MISALIGN_CHK_EN
      if (misaligned) begin
        fault_reg <= 1'b1;
        if (squash_to_drop) begin
          state_reg        <= ST_DROP;
          halt_pending_reg <= 1'b1;
        end else begin
          state_reg <= ST_HALT;
        end
      end else begin
        state_reg <= squash_to_drop ? ST_DROP : ST_ISSUE;
      end
`else
      state_reg <= squash_to_drop ? ST_DROP : ST_ISSUE;
`endif
    end else begin
      case (state_reg)
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if_instr_reg <= imem_rdata;
            if_pc_reg    <= pc_reg;
            pc_reg       <= pc_reg + ADDRESS_WIDTH'(4);
            if_valid_reg <= 1'b1;
            state_reg    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (if_ready) begin
            if_valid_reg <= 1'b0;
            state_reg    <= ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
`ifdef FETCH_MISALIGN_CHK_EN
            state_reg        <= halt_pending_reg ? ST_HALT : ST_ISSUE;
            halt_pending_reg <= 1'b0;
`else
            state_reg <= ST_ISSUE;
`endif
          end
        end
        ST_HALT: begin
          if_valid_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_ISSUE;
        end
      endcase
    end
  end

endmodule
